seq_div_7by3: RTL and testbench
===============================

# seq_div_7by3

Sequential restoring divider, the inverse of the team's 4x3 array multiplier. It takes a 7-bit dividend and a 3-bit divisor and produces a 7-bit quotient and a 3-bit remainder, resolving one quotient bit per clock. A start/busy/done handshake lets a controller recover the multiplicand from a multiplier product, or divide any 7-bit value by a 3-bit value.

## Interface

- Parameters: none. Widths are fixed at dividend 7, divisor 3.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  7  unsigned dividend; sampled when start is accepted.
- divisor  input  3  unsigned divisor; sampled when start is accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; results are valid.
- quotient  output  7  unsigned quotient; held until the next accepted start.
- remainder  output  3  unsigned remainder; held likewise.
- dz  output  1  divide-by-zero flag (see Configuration); held with results.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: 7 iterations, counter 6 down to 0.
  - DONE: one cycle.
- IDLE to RUN on start=1.
  - Latch dividend into the shift register and divisor into a register.
  - Clear the 4-bit partial remainder R and the counter.
- RUN, each cycle:
  - R = {R[2:0], dividend_msb}; shift the dividend register left.
  - If R >= {1'b0, divisor}: R = R - divisor and quotient bit = 1. Otherwise quotient bit = 0.
  - The quotient bit shifts into the LSB of the quotient register.
- RUN to DONE after the 7th iteration. remainder = R[2:0]; R never exceeds divisor-1 after any step.
- DONE:
  - done=1.
  - start=1 goes to RUN, giving back-to-back operation with no IDLE cycle.
  - Otherwise go to IDLE.
- start during RUN is ignored; the latched operands are not disturbed.
- Operand inputs are don't-care outside the accept cycle.
- rst=1 in any state:
  - Next state is IDLE.
  - busy, done, dz = 0; quotient = 0; remainder = 0.
  - An in-flight division is discarded, with no done pulse.
- Invariant at done: dividend == quotient*divisor + remainder, for divisor != 0.

## Timing

- start is accepted at rising edge N.
- busy=1 in cycles N+1 through N+7.
- done=1 in cycle N+8 only; busy=0 in that cycle.
- Latency is 8 cycles from accept to done.
- Throughput is one result per 8 cycles with back-to-back start.
- quotient and remainder update only at the edge entering DONE. Between operations they show the previous result, not partial values.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, dz=0, quotient=7'h00, remainder=3'h0.

## Configuration

- Macro: DIV_BY_ZERO_DETECT_EN.
- Defined:
  - divisor==0 at accept skips RUN and goes directly to DONE at edge N+1.
  - done pulses in cycle N+1; busy stays 0.
  - dz=1, quotient=7'h7F, remainder=3'h0.
  - dz clears at the next accepted start or reset.
- Not defined:
  - No check; dz is tied 0.
  - divisor==0 runs the full 7 iterations.
  - The compare always passes, giving quotient=7'h7F and remainder=dividend[2:0], with done at N+8.

## Test plan

- Reset then idle: rst=1 for 2 cycles -> busy=0, done=0, dz=0, quotient=0, remainder=0; held with start=0.
- Basic: start with dividend=100, divisor=5 -> done exactly 8 cycles later, quotient=20, remainder=0. Also 127/7 -> 18 rem 1.
- Edge values:
  - 5/6 -> quotient=0, remainder=5.
  - 105/7 (multiplier product 15*7) -> quotient=15, remainder=0.
  - 0/3 -> 0 rem 0.
- Handshake: start re-asserted with new operands during RUN -> ignored, result of the first operands. Start held in the DONE cycle with 64/3 -> next done 8 cycles later, 21 rem 1.
- Reset mid-operation: rst at iteration 4 of 100/5 -> no done pulse, outputs zero; a following 50/7 -> 7 rem 1.
- Divide by zero, dividend=0x55, divisor=0:
  - With DIV_BY_ZERO_DETECT_EN: done at N+1, dz=1, quotient=7'h7F, remainder=0.
  - Without it: done at N+8, dz=0, quotient=7'h7F, remainder=3'h5.

Source files
------------

// File: rtl/seq_div_7by3_if.sv
// Operand/result bundle for the 7-by-3 sequential divider.
// master: the controller issuing divisions; slave: the divider itself.
interface seq_div_7by3_if;
    localparam int unsigned DVD_W = 7;
    localparam int unsigned DVS_W = 3;

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz
    );
endinterface

// File: rtl/seq_div_7by3.sv
// Restoring divider, 7-bit dividend by 3-bit divisor, one quotient bit per clock.
// Optional macro DIV_BY_ZERO_DETECT_EN: a zero divisor finishes in one cycle with dz set.
module seq_div_7by3 (
    input logic          clk,
    input logic          rst,
    seq_div_7by3_if.slave bus
);
    localparam int unsigned DVD_W = 7;
    localparam int unsigned DVS_W = 3;
    localparam int unsigned R_W   = DVS_W + 1;
    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] FIRST_ITER = CNT_W'(DVD_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_n;
    // Shared shift register: dividend bits leave at the MSB, quotient bits enter at the LSB.
    logic [DVD_W-1:0] shf_q, shf_n;
    logic [DVS_W-1:0] dvs_q, dvs_n;
    logic [DVS_W-1:0] r_q, r_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [DVD_W-1:0] quo_q, quo_n;
    logic [DVS_W-1:0] rem_q, rem_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             dz_q, dz_n;

    logic [R_W-1:0]   r_shift;
    logic             qbit;
    logic [DVS_W-1:0] r_iter;

    // One restoring step; a passing compare leaves a difference below the divisor, so 3 bits suffice.
    always_comb begin
        r_shift = {r_q, shf_q[DVD_W-1]};
        qbit    = (r_shift >= {1'b0, dvs_q});
        r_iter  = qbit ? DVS_W'(r_shift[DVS_W-1:0] - dvs_q) : r_shift[DVS_W-1:0];
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        shf_n   = shf_q;
        dvs_n   = dvs_q;
        r_n     = r_q;
        cnt_n   = cnt_q;
        quo_n   = quo_q;
        rem_n   = rem_q;
        dz_n    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (bus.start) begin
                    state_n = S_RUN;
                    shf_n   = bus.dividend;
                    dvs_n   = bus.divisor;
                    r_n     = '0;
                    cnt_n   = FIRST_ITER;
                    dz_n    = 1'b0;
`ifdef DIV_BY_ZERO_DETECT_EN
                    if (bus.divisor == '0) begin
                        state_n = S_DONE;
                        dz_n    = 1'b1;
                        quo_n   = '1;
                        rem_n   = '0;
                    end
`endif
                end
            end
            S_RUN: begin
                r_n   = r_iter;
                shf_n = {shf_q[DVD_W-2:0], qbit};
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_n = S_DONE;
                    quo_n   = {shf_q[DVD_W-2:0], qbit};
                    rem_n   = r_iter;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_RUN);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shf_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            shf_q   <= shf_n;
            dvs_q   <= dvs_n;
            r_q     <= r_n;
            cnt_q   <= cnt_n;
            quo_q   <= quo_n;
            rem_q   <= rem_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            dz_q    <= dz_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_seq_div_7by3.sv
// Self-checking bench for seq_div_7by3: directed cases plus random operands against an arithmetic model.
// Honours DIV_BY_ZERO_DETECT_EN for the divide-by-zero expectations.
module tb_seq_div_7by3;
`ifdef DIV_BY_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_7by3_if bus ();

    seq_div_7by3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [6:0]  prev_q;
    logic [2:0]  prev_r;
    logic        prev_dz;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle cycle: no pulse, results held.
    task automatic idle_tick();
        bus.start = 1'b0;
        tick();
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_q",    32'(bus.quotient), 32'(prev_q));
        chk("idle_r",    32'(bus.remainder), 32'(prev_r));
        chk("idle_dz",   32'(bus.dz), 32'(prev_dz));
    endtask

    // Issue one division, then follow it to its done cycle; returns inside the done cycle.
    task automatic do_div(input logic [6:0] a, input logic [2:0] b, input bit noise);
        int         lat;
        int         exp_lat;
        logic [6:0] eq;
        logic [2:0] er;
        logic       edz;
        if (b == 3'd0) begin
            eq      = 7'h7F;
            er      = DZ_EN ? 3'd0 : a[2:0];
            edz     = DZ_EN;
            exp_lat = DZ_EN ? 1 : 8;
        end else begin
            eq      = 7'(a / b);
            er      = 3'(a % b);
            edz     = 1'b0;
            exp_lat = 8;
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 7'($urandom);
        bus.divisor  = 3'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_q_hold", 32'(bus.quotient), 32'(prev_q));
            chk("run_r_hold", 32'(bus.remainder), 32'(prev_r));
            if (noise && lat == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 7'($urandom);
                bus.divisor  = 3'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("latency",   32'(lat), 32'(exp_lat));
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("quotient",  32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("dz",        32'(bus.dz), 32'(edz));
        prev_q  = eq;
        prev_r  = er;
        prev_dz = edz;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        prev_q       = '0;
        prev_r       = '0;
        prev_dz      = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dz",   32'(bus.dz), 32'd0);
        chk("rst_q",    32'(bus.quotient), 32'd0);
        chk("rst_r",    32'(bus.remainder), 32'd0);
        for (int i = 0; i < 3; i++) idle_tick();

        do_div(7'd100, 3'd5, 1'b0); idle_tick();
        do_div(7'd127, 3'd7, 1'b0); idle_tick();
        do_div(7'd5,   3'd6, 1'b0); idle_tick();
        do_div(7'd105, 3'd7, 1'b0); idle_tick();
        do_div(7'd0,   3'd3, 1'b0); idle_tick();

        // start during RUN ignored, then back-to-back start in the DONE cycle
        do_div(7'd20, 3'd3, 1'b1);
        do_div(7'd64, 3'd3, 1'b0);
        idle_tick();

        // reset while iterating discards the division
        bus.start    = 1'b1;
        bus.dividend = 7'd100;
        bus.divisor  = 3'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_q",    32'(bus.quotient), 32'd0);
        chk("midrst_r",    32'(bus.remainder), 32'd0);
        for (int i = 0; i < 8; i++) idle_tick();
        do_div(7'd50, 3'd7, 1'b0); idle_tick();

        do_div(7'h55, 3'd0, 1'b0); idle_tick();
        do_div(7'd9,  3'd2, 1'b0); idle_tick();

        for (int n = 0; n < 40; n++) begin
            logic [6:0] a;
            logic [2:0] b;
            a = 7'($urandom);
            b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) idle_tick();
            do_div(a, b, ($urandom_range(0, 3) == 0));
        end
        idle_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
